// File: rtl/core_controller_pkg.sv
// Shared definitions for the core sequencer: state encoding, reset PC
// default, PC step and the PC-advance rule used when an instruction retires.
package core_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_MEM   = 3'd3,
    ST_HALT  = 3'd4,
    ST_ERROR = 3'd5
  } state_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] PC_INC           = 32'd4;

  // Address of the next instruction: a taken branch redirects to the
  // word-aligned target, otherwise step sequentially (wraps mod 2^32).
  function automatic logic [31:0] next_pc(input logic [31:0] cur_pc,
                                          input logic        taken,
                                          input logic [31:0] target);
    return taken ? {target[31:2], 2'b00} : cur_pc + PC_INC;
  endfunction

endpackage

// File: rtl/core_controller_stage_timer.sv
// Watchdog counter for one handshake stage: cleared on stage entry, counts
// each cycle spent waiting, flags the cycle on which the wait budget ends.
module stage_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic count_i,
  output logic expire_o
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count_q;

  // expire_o marks the TIMEOUT-th waiting cycle (count already at TIMEOUT-1)
  assign expire_o = (count_q == LAST);

  // Wait-cycle counter; holds at the last value so it can never wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= '0;
    end else if (count_i && !expire_o) begin
      count_q <= count_q + 1'b1;
    end
  end

endmodule

// File: rtl/core_controller.sv
// Multi-cycle core sequencer: fetch -> exec -> mem/writeback, with PC and
// retired-count ownership, writeback gating, halt handling and a watchdog.
module core_controller
  import core_controller_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          TIMEOUT  = 16,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic             fetch_start,
  input  logic             fetch_done,
  output logic             latch_fd,
  output logic             latch_de,
  output logic             mw_start,
  input  logic             mw_done,
  input  logic             branch_taken,
  input  logic [31:0]      branch_target,
  input  logic             halt_req,
  output logic [31:0]      pc,
  output logic             wb_commit,
  output logic [CNT_W-1:0] retired,
  output logic             halted,
  output logic             error
);

  state_e           state_q, state_d;
  logic             first_q;
  logic [31:0]      pc_q;
  logic [CNT_W-1:0] retired_q;

  logic waiting;
  logic stage_done;
  logic timer_clear;
  logic timer_count;
  logic timer_expire;
  logic commit;

  // A handshake stage is either waiting on fetch or on memory/writeback
  assign waiting    = (state_q == ST_FETCH) || (state_q == ST_MEM);
  assign stage_done = ((state_q == ST_FETCH) && fetch_done) ||
                      ((state_q == ST_MEM)   && mw_done);

  // Any state change restarts the wait budget for the state being entered
  assign timer_clear = (state_d != state_q);
  assign timer_count = waiting && !stage_done;

  stage_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_stage_timer (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (timer_clear),
    .count_i  (timer_count),
    .expire_o (timer_expire)
  );

  // Instruction retires on the mw_done cycle of MEM
  assign commit = (state_q == ST_MEM) && mw_done;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a done arriving on the expiry cycle still wins
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  state_d = ST_FETCH;
      ST_FETCH: begin
        if (fetch_done) begin
          state_d = ST_EXEC;
        end else if (timer_expire) begin
          state_d = ST_ERROR;
        end
      end
      ST_EXEC:  state_d = ST_MEM;
      ST_MEM: begin
        if (mw_done) begin
          state_d = halt_req ? ST_HALT : ST_FETCH;
        end else if (timer_expire) begin
          state_d = ST_ERROR;
        end
      end
      ST_HALT:  state_d = ST_HALT;
      ST_ERROR: state_d = ST_ERROR;
      default:  state_d = ST_IDLE;
    endcase
  end

  // First-cycle flag so start pulses fire once per stage entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_q <= 1'b0;
    end else begin
      first_q <= timer_clear;
    end
  end

  // PC and retired counter advance only when an instruction commits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      retired_q <= '0;
    end else if (commit) begin
      pc_q      <= next_pc(pc_q, branch_taken, branch_target);
      retired_q <= retired_q + CNT_W'(1);
    end
  end

  assign fetch_start = (state_q == ST_FETCH) && first_q;
  assign latch_fd    = (state_q == ST_FETCH) && fetch_done;
  assign latch_de    = (state_q == ST_EXEC);
  assign mw_start    = (state_q == ST_MEM) && first_q;
  assign wb_commit   = commit;
  assign pc          = pc_q;
  assign retired     = retired_q;
  assign halted      = (state_q == ST_HALT);
  assign error       = (state_q == ST_ERROR);

endmodule

// File: tb/tb_core_controller.sv
// Directed + randomized bench for core_controller. The reference model works
// per instruction: expected PC and retired count, and the cycle position of
// every pulse derived from the chosen fetch / mem latencies.
module tb_core_controller;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          TMO    = 16;
  localparam int          CW     = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          fetch_done = 1'b0;
  logic          mw_done = 1'b0;
  logic          branch_taken = 1'b0;
  logic [31:0]   branch_target = 32'h0;
  logic          halt_req = 1'b0;

  logic          fetch_start, latch_fd, latch_de, mw_start, wb_commit, halted, error;
  logic [31:0]   pc;
  logic [CW-1:0] retired;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0]   m_pc;
  logic [CW-1:0] m_ret;

  core_controller #(
    .RESET_PC (RST_PC),
    .TIMEOUT  (TMO),
    .CNT_W    (CW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .fetch_start   (fetch_start),
    .fetch_done    (fetch_done),
    .latch_fd      (latch_fd),
    .latch_de      (latch_de),
    .mw_start      (mw_start),
    .mw_done       (mw_done),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .halt_req      (halt_req),
    .pc            (pc),
    .wb_commit     (wb_commit),
    .retired       (retired),
    .halted        (halted),
    .error         (error)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply reset, check reset values, release; returns at first FETCH cycle
  task automatic do_reset();
    rst = 1'b1; fetch_done = 1'b0; mw_done = 1'b0;
    branch_taken = 1'b0; halt_req = 1'b0;
    #1;
    tick();
    tick();
    chk("rst_pc", pc, RST_PC);
    chk("rst_retired", retired, 0);
    chk("rst_halted", halted, 0);
    chk("rst_error", error, 0);
    chk("rst_fetch_start", fetch_start, 0);
    rst = 1'b0;
    m_pc  = RST_PC;
    m_ret = '0;
    #2;
    chk("idle_fetch_start", fetch_start, 0);
    tick();
  endtask

  // From first FETCH cycle, fetch with zero latency and land in first MEM cycle
  task automatic to_mem();
    chk("tm_fetch_start", fetch_start, 1);
    fetch_done = 1'b1;
    tick();
    fetch_done = 1'b0;
    tick();
    chk("tm_mw_start", mw_start, 1);
  endtask

  // One full instruction starting at its first FETCH cycle
  task automatic run_instr(input int f_lat, input int m_lat, input bit br,
                           input logic [31:0] tgt, input bit hlt);
    bit d;
    chk("fetch_start", fetch_start, 1);
    chk("pc", pc, m_pc);
    for (int w = 0; w <= f_lat; w++) begin
      d = (w == f_lat);
      fetch_done = d;
      mw_done = 1'($urandom_range(0, 1));
      #2;
      chk("latch_fd", latch_fd, d);
      chk("wb_commit_fetch", wb_commit, 0);
      if (w > 0) chk("fetch_start_once", fetch_start, 0);
      chk("error_fetch", error, 0);
      tick();
    end
    fetch_done = 1'($urandom_range(0, 1));
    mw_done    = 1'($urandom_range(0, 1));
    halt_req   = hlt ? 1'b1 : 1'($urandom_range(0, 1));
    #2;
    chk("latch_de", latch_de, 1);
    chk("wb_commit_exec", wb_commit, 0);
    tick();
    chk("mw_start", mw_start, 1);
    for (int w = 0; w <= m_lat; w++) begin
      d = (w == m_lat);
      mw_done       = d;
      fetch_done    = 1'($urandom_range(0, 1));
      branch_taken  = d ? br : 1'($urandom_range(0, 1));
      branch_target = d ? tgt : $urandom;
      halt_req      = d ? hlt : (hlt | 1'($urandom_range(0, 1)));
      #2;
      chk("wb_commit", wb_commit, d);
      if (w > 0) chk("mw_start_once", mw_start, 0);
      chk("error_mem", error, 0);
      tick();
    end
    mw_done = 1'b0; fetch_done = 1'b0; branch_taken = 1'b0; halt_req = 1'b0;
    m_pc  = br ? (tgt & 32'hFFFF_FFFC) : m_pc + 32'd4;
    m_ret = m_ret + 1;
    chk("retired", retired, m_ret);
    chk("pc_next", pc, m_pc);
    chk("halted", halted, hlt);
    if (hlt) begin
      for (int k = 0; k < 4; k++) begin
        fetch_done = 1'($urandom_range(0, 1));
        mw_done    = 1'($urandom_range(0, 1));
        #2;
        chk("halt_fetch_start", fetch_start, 0);
        chk("halt_mw_start", mw_start, 0);
        chk("halt_wb_commit", wb_commit, 0);
        chk("halt_pc", pc, m_pc);
        chk("halt_halted", halted, 1);
        tick();
      end
      fetch_done = 1'b0; mw_done = 1'b0;
    end
  endtask

  // Hold done low for the full budget and expect the sticky error state
  task automatic expect_timeout(input string tag);
    fetch_done = 1'b0; mw_done = 1'b0;
    for (int w = 0; w < TMO; w++) begin
      #2;
      chk({tag, "_error_early"}, error, 0);
      tick();
    end
    chk({tag, "_error"}, error, 1);
    for (int k = 0; k < 4; k++) begin
      fetch_done = 1'($urandom_range(0, 1));
      mw_done    = 1'($urandom_range(0, 1));
      #2;
      chk({tag, "_no_fetch_start"}, fetch_start, 0);
      chk({tag, "_no_mw_start"}, mw_start, 0);
      chk({tag, "_no_commit"}, wb_commit, 0);
      chk({tag, "_error_sticky"}, error, 1);
      tick();
    end
    fetch_done = 1'b0; mw_done = 1'b0;
  endtask

  initial begin
    int fl, ml, r;
    logic [31:0] saved_ret;

    do_reset();

    // zero-latency back-to-back instructions: pc 0,4,8 and retired 1,2,3
    for (int i = 0; i < 3; i++) run_instr(0, 0, 1'b0, 32'h0, 1'b0);

    // branch to an unaligned target is word-aligned
    run_instr(0, 0, 1'b1, 32'h0000_0103, 1'b0);
    chk("branch_pc", pc, 32'h0000_0100);

    // done on the last allowed wait cycle of each stage
    run_instr(0, TMO - 1, 1'b0, 32'h0, 1'b0);
    run_instr(TMO - 1, 0, 1'b0, 32'h0, 1'b0);

    // fetch never completes
    expect_timeout("fetch_to");

    // memory/writeback never completes
    do_reset();
    to_mem();
    expect_timeout("mem_to");

    // randomized instruction stream, ending with a halt
    do_reset();
    for (int i = 0; i < 40; i++) begin
      r  = int'($urandom_range(0, 9));
      fl = (r == 0) ? 0 : (r == 1) ? TMO - 1 : int'($urandom_range(0, 4));
      r  = int'($urandom_range(0, 9));
      ml = (r == 0) ? 0 : (r == 1) ? TMO - 1 : int'($urandom_range(0, 4));
      run_instr(fl, ml, ($urandom_range(0, 3) == 0), $urandom, (i == 39));
      $display("instr %0d: fetch_lat=%0d mem_lat=%0d pc=%08h retired=%0d",
               i, fl, ml, pc, retired);
    end

    // reset in the middle of MEM, coinciding with mw_done
    do_reset();
    run_instr(0, 0, 1'b0, 32'h0, 1'b0);
    run_instr(0, 0, 1'b0, 32'h0, 1'b0);
    to_mem();
    tick();
    saved_ret = retired;
    chk("pre_rst_retired", saved_ret, 2);
    mw_done = 1'b1;
    rst = 1'b1;
    #1;
    chk("midrst_wb_commit", wb_commit, 0);
    chk("midrst_pc", pc, RST_PC);
    chk("midrst_mw_start", mw_start, 0);
    chk("midrst_retired", retired, 0);
    tick();
    chk("midrst_wb_commit_hold", wb_commit, 0);
    do_reset();
    run_instr(0, 0, 1'b0, 32'h0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
